dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between a CPU port (A) and a DMA port (B).
// Optional per-port grant and contention counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES    = 32,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        err,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0] a_cnt,
  output logic [15:0] b_cnt,
  output logic [15:0] contention_cnt,
`endif
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {UNLOCKED, LOCKED_A, LOCKED_B} lock_e;

  function automatic logic in_range(input logic [31:0] addr);
    return addr <= 32'(MEM_BYTES - 4);
  endfunction

  lock_e             lock_q;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              rr_q;

  logic              vld_p1_q, we_p1_q, inr_p1_q, port_p1_q;
  logic [31:0]       addr_p1_q, wdata_p1_q;

  logic              a_rvalid_q, b_rvalid_q, err_q;
  logic [31:0]       a_rdata_q, b_rdata_q;

  logic              elig_a, elig_b, gnt_a, gnt_b, gnt_any;
  logic              owner_gnt, tmo_fire;
  logic [31:0]       sel_addr, sel_wdata;
  logic              sel_we;

  // Stage p0: arbitration on the live requests
  assign elig_a  = a_req & ((lock_q == UNLOCKED) | (lock_q == LOCKED_A));
  assign elig_b  = b_req & ((lock_q == UNLOCKED) | (lock_q == LOCKED_B));
  // Grants are masked during reset so nothing is accepted into a pipeline being cleared
  assign gnt_a   = rst_n & elig_a & (~elig_b | (rr_q == PORT_B));
  assign gnt_b   = rst_n & elig_b & (~elig_a | (rr_q == PORT_A));
  assign gnt_any = gnt_a | gnt_b;
  assign a_gnt   = gnt_a;
  assign b_gnt   = gnt_b;

  assign sel_addr  = gnt_b ? b_addr  : a_addr;
  assign sel_wdata = gnt_b ? b_wdata : a_wdata;
  assign sel_we    = gnt_b ? b_we    : a_we;

  assign owner_gnt = ((lock_q == LOCKED_A) & gnt_a) | ((lock_q == LOCKED_B) & gnt_b);
  assign tmo_d     = tmo_q + CNT_W'(1);
  assign tmo_fire  = (lock_q != UNLOCKED) & ~owner_gnt & (tmo_d == CNT_W'(LOCK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= UNLOCKED;
      tmo_q  <= '0;
      rr_q   <= PORT_B;
    end else begin
      if (gnt_any) rr_q <= gnt_b;
      case (lock_q)
        UNLOCKED: begin
          tmo_q <= '0;
          if (gnt_a && a_lock)      lock_q <= LOCKED_A;
          else if (gnt_b && b_lock) lock_q <= LOCKED_B;
        end
        LOCKED_A: begin
          if (gnt_a) begin
            tmo_q <= '0;
            if (!a_lock) lock_q <= UNLOCKED;
          end else if (tmo_fire) begin
            tmo_q  <= '0;
            lock_q <= UNLOCKED;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        LOCKED_B: begin
          if (gnt_b) begin
            tmo_q <= '0;
            if (!b_lock) lock_q <= UNLOCKED;
          end else if (tmo_fire) begin
            tmo_q  <= '0;
            lock_q <= UNLOCKED;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: begin
          tmo_q  <= '0;
          lock_q <= UNLOCKED;
        end
      endcase
    end
  end

  // Stage p1: accepted access drives the memory
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      we_p1_q    <= 1'b0;
      inr_p1_q   <= 1'b0;
      port_p1_q  <= PORT_A;
      addr_p1_q  <= '0;
      wdata_p1_q <= '0;
    end else begin
      vld_p1_q <= gnt_any;
      if (gnt_any) begin
        we_p1_q    <= sel_we;
        inr_p1_q   <= in_range(sel_addr);
        port_p1_q  <= gnt_b;
        addr_p1_q  <= sel_addr;
        wdata_p1_q <= sel_wdata;
      end
    end
  end

  assign mem_address    = addr_p1_q;
  assign mem_write_data = wdata_p1_q;
  // Gating with rst_n keeps an in-flight store from committing on the reset edge
  assign mem_write_en   = rst_n & vld_p1_q & we_p1_q & inr_p1_q;

  // Stage p2: load data returned to the owning port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      a_rvalid_q <= vld_p1_q & ~we_p1_q & (port_p1_q == PORT_A);
      b_rvalid_q <= vld_p1_q & ~we_p1_q & (port_p1_q == PORT_B);
      if (vld_p1_q && !we_p1_q && port_p1_q == PORT_A)
        a_rdata_q <= inr_p1_q ? mem_read_data : '0;
      if (vld_p1_q && !we_p1_q && port_p1_q == PORT_B)
        b_rdata_q <= inr_p1_q ? mem_read_data : '0;
      err_q <= (vld_p1_q & ~inr_p1_q) | tmo_fire;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign err      = err_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_cnt_q, b_cnt_q, cont_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      cont_cnt_q <= '0;
    end else begin
      if (gnt_a && a_cnt_q != 16'hFFFF) a_cnt_q <= a_cnt_q + 16'd1;
      if (gnt_b && b_cnt_q != 16'hFFFF) b_cnt_q <= b_cnt_q + 16'd1;
      if (a_req && b_req && cont_cnt_q != 16'hFFFF) cont_cnt_q <= cont_cnt_q + 16'd1;
    end
  end

  assign a_cnt          = a_cnt_q;
  assign b_cnt          = b_cnt_q;
  assign contention_cnt = cont_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed cycle-by-cycle bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int   NV = 37;

  logic        clk, rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_en;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_cnt, b_cnt, contention_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [8] = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                           32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007};

  always @(posedge clk)
    if (mem_write_en && mem_address < 32) mem[mem_address[4:2]] <= mem_write_data;

  assign mem_read_data = (mem_address < 32) ? mem[mem_address[4:2]] : 32'hDEADBEEF;

  dmem_arbiter #(.MEM_BYTES(32), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .err(err),
`ifdef DMEM_ARB_STATS_EN
    .a_cnt(a_cnt), .b_cnt(b_cnt), .contention_cnt(contention_cnt),
`endif
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ar, aw, al; logic [31:0] aa, ad;
    logic br, bw, bl; logic [31:0] ba, bd;
    logic eag, ebg, emwe; logic [31:0] ema;
    logic earv; logic [31:0] eard;
    logic ebrv; logic [31:0] ebrd;
    logic eerr;
  } vec_t;

  vec_t v [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    a_req = r.ar; a_we = r.aw; a_lock = r.al; a_addr = r.aa; a_wdata = r.ad;
    b_req = r.br; b_we = r.bw; b_lock = r.bl; b_addr = r.ba; b_wdata = r.bd;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;

    // ar aw al aa ad | br bw bl ba bd | eag ebg emwe ema | earv eard | ebrv ebrd | eerr
    v[0]  = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd0,  L,32'h0,        L,32'h0,        L};
    v[1]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          H,L,L,32'd0,  L,32'h0,        L,32'h0,        L};
    v[2]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          L,H,L,32'd0,  L,32'h0,        L,32'h0,        L};
    v[3]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          H,L,L,32'd4,  H,32'hA0000000, L,32'h0,        L};
    v[4]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          L,H,L,32'd0,  L,32'h0,        H,32'hA0000001, L};
    v[5]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          H,L,L,32'd4,  H,32'hA0000000, L,32'h0,        L};
    v[6]  = '{H,L,L,32'd0,32'h0,          H,L,L,32'd4,32'h0,          L,H,L,32'd0,  L,32'h0,        H,32'hA0000001, L};
    v[7]  = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd4,  H,32'hA0000000, L,32'h0,        L};
    v[8]  = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd4,  L,32'h0,        H,32'hA0000001, L};
    v[9]  = '{H,H,L,32'd8,32'h11223344,   L,L,L,32'd0,32'h0,          H,L,L,32'd4,  L,32'h0,        L,32'h0,        L};
    v[10] = '{H,L,L,32'd8,32'h0,          L,L,L,32'd0,32'h0,          H,L,H,32'd8,  L,32'h0,        L,32'h0,        L};
    v[11] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd8,  L,32'h0,        L,32'h0,        L};
    v[12] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd8,  H,32'h11223344, L,32'h0,        L};
    v[13] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd32,32'h0,         L,H,L,32'd8,  L,32'h0,        L,32'h0,        L};
    v[14] = '{H,L,L,32'd28,32'h0,         L,L,L,32'd0,32'h0,          H,L,L,32'd32, L,32'h0,        L,32'h0,        L};
    v[15] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd28, L,32'h0,        H,32'h0,        H};
    v[16] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd28, H,32'hA0000007, L,32'h0,        L};
    v[17] = '{L,L,L,32'd0,32'h0,          H,H,L,32'd36,32'hFFFFFFFF,  L,H,L,32'd28, L,32'h0,        L,32'h0,        L};
    v[18] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd36, L,32'h0,        L,32'h0,        L};
    v[19] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd36, L,32'h0,        L,32'h0,        H};
    v[20] = '{H,L,H,32'd8,32'h0,          H,H,L,32'd12,32'hCAFEF00D,  H,L,L,32'd36, L,32'h0,        L,32'h0,        L};
    v[21] = '{L,L,L,32'd0,32'h0,          H,H,L,32'd12,32'hCAFEF00D,  L,L,L,32'd8,  L,32'h0,        L,32'h0,        L};
    v[22] = '{L,L,L,32'd0,32'h0,          H,H,L,32'd12,32'hCAFEF00D,  L,L,L,32'd8,  H,32'h11223344, L,32'h0,        L};
    v[23] = '{H,H,L,32'd8,32'h55667788,   H,H,L,32'd12,32'hCAFEF00D,  H,L,L,32'd8,  L,32'h0,        L,32'h0,        L};
    v[24] = '{L,L,L,32'd0,32'h0,          H,H,L,32'd12,32'hCAFEF00D,  L,H,H,32'd8,  L,32'h0,        L,32'h0,        L};
    v[25] = '{H,L,L,32'd12,32'h0,         L,L,L,32'd0,32'h0,          H,L,H,32'd12, L,32'h0,        L,32'h0,        L};
    v[26] = '{H,L,L,32'd8,32'h0,          L,L,L,32'd0,32'h0,          H,L,L,32'd12, L,32'h0,        L,32'h0,        L};
    v[27] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd8,  H,32'hCAFEF00D, L,32'h0,        L};
    v[28] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd8,  H,32'h55667788, L,32'h0,        L};
    v[29] = '{H,L,H,32'd16,32'h0,         L,L,L,32'd0,32'h0,          H,L,L,32'd8,  L,32'h0,        L,32'h0,        L};
    v[30] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd20,32'h0,         L,L,L,32'd16, L,32'h0,        L,32'h0,        L};
    v[31] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd20,32'h0,         L,L,L,32'd16, H,32'hA0000004, L,32'h0,        L};
    v[32] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd20,32'h0,         L,L,L,32'd16, L,32'h0,        L,32'h0,        L};
    v[33] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd20,32'h0,         L,L,L,32'd16, L,32'h0,        L,32'h0,        L};
    v[34] = '{L,L,L,32'd0,32'h0,          H,L,L,32'd20,32'h0,         L,H,L,32'd16, L,32'h0,        L,32'h0,        H};
    v[35] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd20, L,32'h0,        L,32'h0,        L};
    v[36] = '{L,L,L,32'd0,32'h0,          L,L,L,32'd0,32'h0,          L,L,L,32'd20, L,32'h0,        H,32'hA0000005, L};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 drive(v[i]);
      #4;
      check($sformatf("row%0d a_gnt", i), a_gnt, v[i].eag);
      check($sformatf("row%0d b_gnt", i), b_gnt, v[i].ebg);
      check($sformatf("row%0d mem_write_en", i), mem_write_en, v[i].emwe);
      check($sformatf("row%0d mem_address", i), mem_address, v[i].ema);
      check($sformatf("row%0d a_rvalid", i), a_rvalid, v[i].earv);
      check($sformatf("row%0d b_rvalid", i), b_rvalid, v[i].ebrv);
      check($sformatf("row%0d err", i), err, v[i].eerr);
      if (v[i].earv || i == 0) check($sformatf("row%0d a_rdata", i), a_rdata, v[i].eard);
      if (v[i].ebrv || i == 0) check($sformatf("row%0d b_rdata", i), b_rdata, v[i].ebrd);
    end

    // Reset asserted in the cycle after a store grant must drop that store
    @(posedge clk);
    #1 a_req = 1; a_we = 1; a_lock = 0; a_addr = 32'd24; a_wdata = 32'hDEADBEEF;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
    #4 check("rst store a_gnt", a_gnt, 1'b1);
    @(posedge clk);
    #1 a_req = 0; a_we = 0; rst_n = 1'b0;
    #4 check("rst cycle mem_write_en", mem_write_en, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #4;
    check("post rst mem_write_en", mem_write_en, 1'b0);
    check("post rst mem_address", mem_address, 32'h0);
    check("post rst a_rvalid", a_rvalid, 1'b0);
    check("post rst err", err, 1'b0);
    check("post rst a_rdata", a_rdata, 32'h0);
    @(posedge clk);
    #1 a_req = 1; a_we = 0; a_addr = 32'd24;
    #4 check("readback a_gnt", a_gnt, 1'b1);
    @(posedge clk);
    #1 a_req = 0;
    #4 check("readback mem_address", mem_address, 32'd24);
    @(posedge clk);
    #5;
    check("readback a_rvalid", a_rvalid, 1'b1);
    check("readback a_rdata", a_rdata, 32'hA0000006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
